// File: rtl/cnn_div_seq_22ns_12ns.sv
// Sequential unsigned radix-2 restoring divider: one quotient bit per enabled clock.
// Valid/ready on both sides, single division in flight, result held until consumed.
module cnn_div_seq_22ns_12ns #(
    parameter int unsigned DIVIDEND_WIDTH = 22,
    parameter int unsigned DIVISOR_WIDTH  = 12
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      ce,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      div_by_zero
);

    localparam int unsigned CntW = $clog2(DIVIDEND_WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(DIVIDEND_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e                    state_q;
    logic [CntW-1:0]           cnt_q;
    logic [DIVIDEND_WIDTH-1:0] q_q;
    logic [DIVISOR_WIDTH-1:0]  r_q;
    logic [DIVISOR_WIDTH-1:0]  d_q;
    logic [DIVIDEND_WIDTH-1:0] quotient_q;
    logic [DIVISOR_WIDTH-1:0]  remainder_q;
    logic                      dbz_q;

    logic [DIVISOR_WIDTH:0]    rem_wide;
    logic                      trial_ok;
    logic [DIVISOR_WIDTH-1:0]  r_next;
    logic [DIVIDEND_WIDTH-1:0] q_next;

    // The restored partial remainder is always < divisor, so r_q needs only DIVISOR_WIDTH
    // bits; the shifted value carries the extra bit for the trial subtraction.
    always_comb begin
        rem_wide = {r_q, q_q[DIVIDEND_WIDTH-1]};
        trial_ok = (rem_wide >= {1'b0, d_q});
        r_next   = trial_ok ? (rem_wide[DIVISOR_WIDTH-1:0] - d_q) : rem_wide[DIVISOR_WIDTH-1:0];
        q_next   = {q_q[DIVIDEND_WIDTH-2:0], trial_ok};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            q_q         <= '0;
            r_q         <= '0;
            d_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else if (ce) begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        if (divisor == '0) begin
                            quotient_q  <= '1;
                            remainder_q <= '0;
                            dbz_q       <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            q_q     <= dividend;
                            r_q     <= '0;
                            d_q     <= divisor;
                            cnt_q   <= '0;
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    q_q   <= q_next;
                    r_q   <= r_next;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        quotient_q  <= q_next;
                        remainder_q <= r_next;
                        dbz_q       <= 1'b0;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready    = (state_q == StIdle) && ce;
    assign out_valid   = (state_q == StDone);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
